cpu: RTL and testbench

Minimal 16-bit multi-cycle accumulator processor with internal unified program/data memory and a single I/O port on a shared tri-state bus. It is the top-level compute block. The memory is preloaded with a self-test program that emits the values 0..17 on the I/O port and then halts.

---
 rtl/cpu.sv | 116 +++++++++++
 tb/tb_cpu.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/cpu.sv
// Minimal 16-bit multi-cycle accumulator CPU with a 256x16 unified memory and one
// I/O port on a shared tri-state bus. Each instruction is one FETCH cycle then one
// EXEC cycle; the memory boots holding a self-test program that emits 0..17.
module cpu (
  input  logic        clk,
  input  logic        reset_bar,
  output logic [15:0] addr,
  inout  wire  [15:0] bus,
  output logic        DI,
  output logic        DO
);

  typedef enum logic [1:0] {StFetch, StExec, StHalt} state_e;

  localparam logic [3:0] OpLdi  = 4'h1;
  localparam logic [3:0] OpLd   = 4'h2;
  localparam logic [3:0] OpSt   = 4'h3;
  localparam logic [3:0] OpAdd  = 4'h4;
  localparam logic [3:0] OpAddi = 4'h5;
  localparam logic [3:0] OpSub  = 4'h6;
  localparam logic [3:0] OpJmp  = 4'h7;
  localparam logic [3:0] OpJz   = 4'h8;
  localparam logic [3:0] OpJnz  = 4'h9;
  localparam logic [3:0] OpOut  = 4'hA;
  localparam logic [3:0] OpIn   = 4'hB;
  localparam logic [3:0] OpSubi = 4'hC;
  localparam logic [3:0] OpHalt = 4'hF;

  state_e      r_state;
  logic [15:0] r_pc;
  logic [15:0] r_ir;
  logic [15:0] r_a;

  // Boot image; reset leaves memory contents untouched.
  logic [15:0] r_mem [256] = '{
    0: 16'h1000,  // LDI 0
    1: 16'hA000,  // OUT
    2: 16'h5001,  // ADDI 1
    3: 16'h3080,  // ST 0x80
    4: 16'hC012,  // SUBI 18
    5: 16'h8008,  // JZ 8
    6: 16'h2080,  // LD 0x80
    7: 16'h7001,  // JMP 1
    8: 16'hF000,  // HALT
    default: 16'h0000
  };

  logic [3:0]  w_op;
  logic [15:0] w_k;
  logic [15:0] w_rdata;
  logic        w_exec;

  assign w_op    = r_ir[15:12];
  assign w_k     = {4'h0, r_ir[11:0]};
  assign w_exec  = (r_state == StExec);
  // Memory aliases every 256 words.
  assign w_rdata = r_mem[addr[7:0]];

  // Output decode from registered state and IR.
  always_comb begin
    addr = w_exec ? w_k : r_pc;
    DI   = w_exec && (w_op == OpOut);
    DO   = w_exec && (w_op == OpIn);
  end

  assign bus = DI ? r_a : 16'hzzzz;

  // Store commits at the end-of-EXEC edge.
  always_ff @(posedge clk) begin
    if (w_exec && (w_op == OpSt)) begin
      r_mem[w_k[7:0]] <= r_a;
    end
  end

  // Main FETCH/EXEC/HALT sequencer with architectural register updates.
  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      r_state <= StFetch;
      r_pc    <= 16'h0000;
      r_ir    <= 16'h0000;
      r_a     <= 16'h0000;
    end else begin
      case (r_state)
        StFetch: begin
          r_ir    <= w_rdata;
          r_pc    <= r_pc + 16'h0001;
          r_state <= StExec;
        end
        StExec: begin
          r_state <= StFetch;
          case (w_op)
            OpLdi:  r_a <= w_k;
            OpLd:   r_a <= w_rdata;
            OpAdd:  r_a <= r_a + w_rdata;
            OpAddi: r_a <= r_a + w_k;
            OpSub:  r_a <= r_a - w_rdata;
            OpSubi: r_a <= r_a - w_k;
            OpIn:   r_a <= bus;
            OpJmp:  r_pc <= w_k;
            OpJz: begin
              if (r_a == 16'h0000) r_pc <= w_k;
            end
            OpJnz: begin
              if (r_a != 16'h0000) r_pc <= w_k;
            end
            OpHalt: r_state <= StHalt;
            default: ;  // NOP, ST (memory side), OUT (decode only), D, E
          endcase
        end
        StHalt:  r_state <= StHalt;
        default: r_state <= StFetch;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu.sv
// Scoreboard bench for cpu: stimulus pushes expected OUT words (value and the clock
// edge after which DI should be seen); a monitor pops and compares on every DI pulse.
module tb_cpu;

  logic        clk;
  logic        reset_bar;
  logic [15:0] addr;
  wire  [15:0] bus;
  logic        DI;
  logic        DO;
  logic [15:0] in_val;

  typedef struct {
    logic [15:0] val;
    int          edge_no;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   failures;
  int   edge_cnt;
  int   di_total;
  int   do_total;
  int   do_edge;

  cpu dut (
    .clk      (clk),
    .reset_bar(reset_bar),
    .addr     (addr),
    .bus      (bus),
    .DI       (DI),
    .DO       (DO)
  );

  // Bench acts as the input device while the CPU strobes DO.
  assign bus = DO ? in_val : 16'hzzzz;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rising edges since reset release; edge n starts the cycle numbered n+1.
  always @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) edge_cnt <= 0;
    else            edge_cnt <= edge_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pop the scoreboard on every DI pulse, record DO pulses.
  always @(negedge clk) begin
    if (reset_bar) begin
      if (DI) begin
        exp_t e;
        di_total++;
        if (sb.size() == 0) begin
          check("unexpected_di", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("out_value", {16'h0, bus}, {16'h0, e.val});
          check("out_cycle", edge_cnt, e.edge_no);
        end
      end
      if (DO) begin
        do_total++;
        do_edge = edge_cnt;
      end
    end
  end

  task automatic push_exp(input logic [15:0] v, input int e);
    exp_t x;
    x.val     = v;
    x.edge_no = e;
    sb.push_back(x);
  endtask

  // Self-test loop is seven instructions of two cycles each.
  task automatic push_selftest();
    for (int k = 0; k < 18; k++) push_exp(16'(k), 3 + 14 * k);
  endtask

  task automatic wait_sb(input int budget, input string name);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, sb.size(), 0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    di_total  = 0;
    do_total  = 0;
    do_edge   = -1;
    reset_bar = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr"}, {16'h0, addr}, 32'h0);
    check({tag, "_di"}, {31'h0, DI}, 32'h0);
    check({tag, "_do"}, {31'h0, DO}, 32'h0);
  endtask

  initial begin
    int n;
    checks    = 0;
    failures  = 0;
    di_total  = 0;
    do_total  = 0;
    do_edge   = -1;
    in_val    = 16'h0000;
    reset_bar = 1'b0;

    // Reset held across edges.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");

    // Self-test program.
    push_selftest();
    release_reset();
    #1 check("cycle1_addr", {16'h0, addr}, 32'h0);
    wait_sb(400, "selftest_drain");
    while (edge_cnt < 1000) @(negedge clk);
    check("selftest_di_count", di_total, 18);
    check("selftest_do_count", do_total, 0);
    check("halt_di", {31'h0, DI}, 32'h0);
    check("halt_do", {31'h0, DO}, 32'h0);
    check("halt_addr", {16'h0, addr}, 32'h9);

    // Asynchronous reset during HALT.
    @(posedge clk);
    #3 reset_bar = 1'b0;
    #1 check_reset_outputs("reset_halt");

    // Reset mid-run after the fifth output.
    push_selftest();
    release_reset();
    n = 0;
    while (di_total < 5 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("midrun_reach5", {31'h0, di_total >= 5}, 32'h1);
    repeat (3) @(posedge clk);
    #2 reset_bar = 1'b0;
    #1 check_reset_outputs("reset_midrun");
    sb.delete();
    push_selftest();
    release_reset();
    wait_sb(400, "midrun_drain");
    repeat (40) @(negedge clk);
    check("midrun_di_count", di_total, 18);

    // IN path: IN; OUT; HALT.
    reset_bar = 1'b0;
    @(negedge clk);
    dut.r_mem[0] = 16'hB000;
    dut.r_mem[1] = 16'hA000;
    dut.r_mem[2] = 16'hF000;
    in_val = 16'h1234;
    push_exp(16'h1234, 3);
    release_reset();
    wait_sb(20, "in_drain");
    repeat (10) @(negedge clk);
    check("in_do_count", do_total, 1);
    check("in_do_cycle", do_edge, 1);
    check("in_di_count", di_total, 1);

    // Arithmetic wrap: LDI 0; SUBI 1; OUT; JNZ 0; HALT.
    reset_bar = 1'b0;
    @(negedge clk);
    dut.r_mem[0] = 16'h1000;
    dut.r_mem[1] = 16'hC001;
    dut.r_mem[2] = 16'hA000;
    dut.r_mem[3] = 16'h9000;
    dut.r_mem[4] = 16'hF000;
    push_exp(16'hFFFF, 5);
    push_exp(16'hFFFF, 13);
    release_reset();
    n = 0;
    while (edge_cnt < 8 && n < 20) begin
      @(negedge clk);
      n++;
    end
    // Fetch after JNZ must come from address 0, not 4.
    check("wrap_branch_addr", {16'h0, addr}, 32'h0);
    wait_sb(30, "wrap_drain");
    reset_bar = 1'b0;
    #1 check_reset_outputs("reset_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
